// File: rtl/pwm_channel_scheduler.sv
// -----------------------------------------------------------------------------
// pwm_channel_scheduler
//
// Shares one RC-PWM pulse-width measurement engine across NUM_CH servo inputs.
// A round-robin arbiter grants the next enabled channel. The scheduler waits for
// that channel to be low, then for a clean rising edge, and counts the high time
// in clk cycles (1 MHz clk gives microseconds). The width is then classified and
// reported as a one-cycle result pulse.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   ena           in   design selected; low behaves like run=0
//   run           in   scheduler enable
//   ch_in         in   raw asynchronous PWM inputs, one bit per channel
//   ch_en         in   per-channel enable mask, sampled only at grant
//   busy          out  high in every state except IDLE
//   ch_sel        out  channel currently granted
//   result_valid  out  one-cycle pulse when a new result is presented
//   result_ch     out  channel of the last result (held)
//   result_width  out  measured high time in cycles (held)
//   result_class  out  00 LOW, 01 MID, 10 HIGH, 11 FAULT (held)
// -----------------------------------------------------------------------------
module pwm_channel_scheduler #(
    parameter int NUM_CH             = 4,
    parameter int CNT_W              = 15,
    parameter int MAX_COUNTER_VALUE  = 2000,
    parameter int HIGH_COUNTER_VALUE = 1900,
    parameter int LOW_COUNTER_VALUE  = 1100,
    parameter int TIMEOUT_VALUE      = 25000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      run,
    input  logic [NUM_CH-1:0]         ch_in,
    input  logic [NUM_CH-1:0]         ch_en,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      result_valid,
    output logic [$clog2(NUM_CH)-1:0] result_ch,
    output logic [CNT_W-1:0]          result_width,
    output logic [1:0]                result_class
);

    localparam int SEL_W = $clog2(NUM_CH);

    localparam logic [CNT_W-1:0] MAX_W  = CNT_W'(MAX_COUNTER_VALUE);
    localparam logic [CNT_W-1:0] HIGH_W = CNT_W'(HIGH_COUNTER_VALUE);
    localparam logic [CNT_W-1:0] LOW_W  = CNT_W'(LOW_COUNTER_VALUE);
    localparam logic [CNT_W-1:0] TO_W   = CNT_W'(TIMEOUT_VALUE);

    localparam logic [1:0] CLS_LOW   = 2'b00;
    localparam logic [1:0] CLS_MID   = 2'b01;
    localparam logic [1:0] CLS_HIGH  = 2'b10;
    localparam logic [1:0] CLS_FAULT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        WAIT_RISE,
        MEASURE,
        REPORT
    } state_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Boundary values themselves classify as MID.
    function automatic logic [1:0] classify(input logic [CNT_W-1:0] w);
        if (w > HIGH_W) begin
            return CLS_HIGH;
        end
        if (w < LOW_W) begin
            return CLS_LOW;
        end
        return CLS_MID;
    endfunction

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  rr_q, rr_d;
    logic [SEL_W-1:0]  ch_sel_q, ch_sel_d;
    logic [CNT_W-1:0]  to_q, to_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic              rv_q, rv_d;
    logic [SEL_W-1:0]  rch_q, rch_d;
    logic [CNT_W-1:0]  rw_q, rw_d;
    logic [1:0]        rcl_q, rcl_d;

    // Two flops per channel for metastability, plus a third flop so the
    // selected channel's previous synced value is available for edge detection
    // without carrying over history from the previously granted channel.
    logic [NUM_CH-1:0] sync1_q, sync2_q, sync3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= ch_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    logic s_cur;
    logic s_prev;
    logic go;

    assign s_cur  = sync2_q[ch_sel_q];
    assign s_prev = sync3_q[ch_sel_q];
    assign go     = run & ena;

    // Round-robin search starting just after the last granted channel.
    logic [SEL_W-1:0] grant_ch;
    logic [SEL_W-1:0] cand;
    logic             grant_found;

    always_comb begin
        grant_found = 1'b0;
        grant_ch    = rr_q;
        cand        = rr_q;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = SEL_W'((int'(rr_q) + i) % NUM_CH);
            if (!grant_found && ch_en[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    logic             take_grant;
    logic             do_report;
    logic             rep_fault;
    logic [CNT_W-1:0] rep_w;
    logic [CNT_W-1:0] width_inc;

    assign width_inc = sat_inc(width_q);

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        ch_sel_d   = ch_sel_q;
        to_d       = to_q;
        width_d    = width_q;
        rv_d       = 1'b0;
        rch_d      = rch_q;
        rw_d       = rw_q;
        rcl_d      = rcl_q;
        take_grant = 1'b0;
        do_report  = 1'b0;
        rep_fault  = 1'b0;
        rep_w      = width_q;

        case (state_q)
            IDLE, REPORT: begin
                if (go && grant_found) begin
                    take_grant = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            // The timeout budget spans SYNC and WAIT_RISE together.
            SYNC, WAIT_RISE: begin
                to_d = sat_inc(to_q);
                if (!go) begin
                    state_d = IDLE;
                end else if (to_d >= TO_W) begin
                    do_report = 1'b1;
                    rep_fault = 1'b1;
                    rep_w     = '0;
                end else if (state_q == SYNC) begin
                    // Only a low level here guarantees the next high is a whole pulse.
                    if (!s_cur) begin
                        state_d = WAIT_RISE;
                    end
                end else if (s_cur && !s_prev) begin
                    state_d = MEASURE;
                    width_d = CNT_W'(1);
                end
            end

            MEASURE: begin
                if (!go) begin
                    state_d = IDLE;
                end else if (s_cur) begin
                    if (width_inc >= MAX_W) begin
                        do_report = 1'b1;
                        rep_fault = 1'b1;
                        rep_w     = MAX_W;
                    end else begin
                        width_d = width_inc;
                    end
                end else begin
                    do_report = 1'b1;
                    rep_w     = width_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_grant) begin
            state_d  = SYNC;
            rr_d     = grant_ch;
            ch_sel_d = grant_ch;
            to_d     = '0;
        end

        if (do_report) begin
            state_d = REPORT;
            rv_d    = 1'b1;
            rch_d   = ch_sel_q;
            rw_d    = rep_w;
            rcl_d   = rep_fault ? CLS_FAULT : classify(rep_w);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= SEL_W'(NUM_CH - 1);
            ch_sel_q <= '0;
            to_q     <= '0;
            width_q  <= '0;
            rv_q     <= 1'b0;
            rch_q    <= '0;
            rw_q     <= '0;
            rcl_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            ch_sel_q <= ch_sel_d;
            to_q     <= to_d;
            width_q  <= width_d;
            rv_q     <= rv_d;
            rch_q    <= rch_d;
            rw_q     <= rw_d;
            rcl_q    <= rcl_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign ch_sel       = ch_sel_q;
    assign result_valid = rv_q;
    assign result_ch    = rch_q;
    assign result_width = rw_q;
    assign result_class = rcl_q;

endmodule
